// File: rtl/attack_sequencer_if.sv
// attack_sequencer_if: button/position/fight-state inputs and damage-side outputs of the attack sequencer
interface attack_sequencer_if #(
  parameter int POS_W = 10
);
  logic             tick;
  logic [1:0]       fight_state;
  logic             btn_1;
  logic             btn_2;
  logic [POS_W-1:0] pos_1;
  logic [POS_W-1:0] pos_2;
  logic             in_range;
  logic             attack_state_1;
  logic             attack_state_2;
  logic             busy_1;
  logic             busy_2;
  logic             dmg_to_1;
  logic             dmg_to_2;
  modport master (
    input  tick, fight_state, btn_1, btn_2, pos_1, pos_2,
    output in_range, attack_state_1, attack_state_2, busy_1, busy_2, dmg_to_1, dmg_to_2
  );
  modport slave (
    output tick, fight_state, btn_1, btn_2, pos_1, pos_2,
    input  in_range, attack_state_1, attack_state_2, busy_1, busy_2, dmg_to_1, dmg_to_2
  );
endinterface

// File: rtl/attack_sequencer.sv
// attack_sequencer: per-player windup/active/recovery FSMs producing one-shot damage strobes
module attack_sequencer #(
  parameter int WINDUP_TICKS  = 2,
  parameter int ACTIVE_TICKS  = 2,
  parameter int RECOVER_TICKS = 3,
  parameter int HIT_RANGE     = 40,
  parameter int POS_W         = 10,
  parameter int CNT_W         = 4
) (
  input logic clk,
  input logic reset,
  attack_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, WINDUP, ACTIVE, RECOVER} state_t;
  localparam logic [POS_W-1:0] RANGE = POS_W'(HIT_RANGE);
  logic             w_fight;
  logic [POS_W-1:0] w_diff;
  logic             r_in_range;
  logic [1:0]       w_btn;
  logic [1:0]       w_active;
  logic [1:0]       w_busy;
  logic [1:0]       w_dmg;
  assign w_fight = bus.fight_state == 2'b00;
  assign w_btn   = {bus.btn_2, bus.btn_1};
  assign w_diff  = bus.pos_1 >= bus.pos_2 ? bus.pos_1 - bus.pos_2 : bus.pos_2 - bus.pos_1;
  always_ff @(posedge clk) begin
    if (!reset) r_in_range <= 1'b0;
    else r_in_range <= w_diff <= RANGE;
  end
  for (genvar p = 0; p < 2; p++) begin : g_player
    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic             r_prev, r_pend, w_pend, r_done, w_done, r_dmg, w_hit, w_rise, w_last;
    assign w_rise = w_btn[p] & ~r_prev;
    assign w_last = r_cnt == (r_state == WINDUP ? CNT_W'(WINDUP_TICKS - 1) :
                              r_state == ACTIVE ? CNT_W'(ACTIVE_TICKS - 1) : CNT_W'(RECOVER_TICKS - 1));
    // r_prev keeps tracking the button through reset so a button held across reset is not a fresh press
    always_ff @(posedge clk) begin
      r_prev <= w_btn[p];
      if (!reset) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_pend  <= 1'b0;
        r_done  <= 1'b0;
        r_dmg   <= 1'b0;
      end else begin
        r_state <= w_state;
        r_cnt   <= w_cnt;
        r_pend  <= w_pend;
        r_done  <= w_done;
        r_dmg   <= w_hit;
      end
    end
    always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_done  = r_done;
      w_pend  = r_pend | w_rise;
      w_hit   = 1'b0;
      if (!w_fight) begin
        w_state = IDLE;
        w_cnt   = '0;
        w_pend  = 1'b0;
      end else if (bus.tick) begin
        w_pend = 1'b0;
        w_hit  = r_state == ACTIVE && r_in_range && !r_done;
        w_done = r_done | w_hit;
        if (r_state == IDLE) begin
          if (r_pend | w_rise) begin
            w_state = WINDUP;
            w_cnt   = '0;
            w_done  = 1'b0;
          end
        end else begin
          w_cnt = w_last ? '0 : r_cnt + 1'b1;
          if (w_last) w_state = r_state == WINDUP ? ACTIVE : r_state == ACTIVE ? RECOVER : IDLE;
        end
      end
    end
    assign w_active[p] = r_state == ACTIVE;
    assign w_busy[p]   = r_state != IDLE;
    assign w_dmg[p]    = r_dmg;
  end
  assign bus.in_range       = r_in_range;
  assign bus.attack_state_1 = w_active[0];
  assign bus.attack_state_2 = w_active[1];
  assign bus.busy_1         = w_busy[0];
  assign bus.busy_2         = w_busy[1];
  assign bus.dmg_to_2       = w_dmg[0];
  assign bus.dmg_to_1       = w_dmg[1];
endmodule
